// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// States, opcode map and ALU function codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_STORE = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_BEQZ  = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_SHL   = 4'b1001;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SHL  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b111;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps the latched opcode to instruction class,
// operand select and ALU function. Purely combinational.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int ALUW = 3
) (
    input  logic [OPW-1:0]  ir_op,
    output logic            is_alu,
    output logic            is_load,
    output logic            is_store,
    output logic            is_branch,
    output logic            is_halt,
    output logic            alusrc,
    output logic [ALUW-1:0] aluop
);

    always_comb begin
        is_alu    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_halt   = 1'b0;
        alusrc    = 1'b0;
        aluop     = ALUW'(ALU_PASS);
        unique case (1'b1)
            ir_op == OPW'(OP_STORE): begin
                is_store = 1'b1;
                alusrc   = 1'b1;
                aluop    = ALUW'(ALU_ADD);
            end
            ir_op == OPW'(OP_LOAD): begin
                is_load = 1'b1;
                alusrc  = 1'b1;
                aluop   = ALUW'(ALU_ADD);
            end
            ir_op == OPW'(OP_ADD): begin
                is_alu = 1'b1;
                aluop  = ALUW'(ALU_ADD);
            end
            ir_op == OPW'(OP_ADDI): begin
                is_alu = 1'b1;
                alusrc = 1'b1;
                aluop  = ALUW'(ALU_ADD);
            end
            ir_op == OPW'(OP_SUB): begin
                is_alu = 1'b1;
                aluop  = ALUW'(ALU_SUB);
            end
            ir_op == OPW'(OP_AND): begin
                is_alu = 1'b1;
                aluop  = ALUW'(ALU_AND);
            end
            ir_op == OPW'(OP_OR): begin
                is_alu = 1'b1;
                aluop  = ALUW'(ALU_OR);
            end
            ir_op == OPW'(OP_XOR): begin
                is_alu = 1'b1;
                aluop  = ALUW'(ALU_XOR);
            end
            ir_op == OPW'(OP_SHL): begin
                is_alu = 1'b1;
                aluop  = ALUW'(ALU_SHL);
            end
            ir_op == OPW'(OP_BEQZ): begin
                is_branch = 1'b1;
                aluop     = ALUW'(ALU_SUB);
            end
            ir_op == OPW'(OP_HALT): begin
                is_halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// data-memory handshake, wait timeout, HALT and retired counter.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int ALUW     = 3,
    parameter int MAX_WAIT = 8,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OPW-1:0]  instr,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            InstrLoad,
    output logic            PCWrite,
    output logic            Branch,
    output logic            ALUSrc,
    output logic [ALUW-1:0] ALUOp,
    output logic            RegWrite,
    output logic            MemtoReg,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            halted,
    output logic            mem_err,
    output logic [CNTW-1:0] retired
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);

    state_t          state;
    logic [OPW-1:0]  ir_op;
    logic [WW-1:0]   wait_cnt;

    logic            is_alu;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_halt;
    logic            d_alusrc;
    logic [ALUW-1:0] d_aluop;
    logic            retire;

    ctrl_decode #(
        .OPW  (OPW),
        .ALUW (ALUW)
    ) u_dec (
        .ir_op     (ir_op),
        .is_alu    (is_alu),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_halt   (is_halt),
        .alusrc    (d_alusrc),
        .aluop     (d_aluop)
    );

    // Instruction completes: single-cycle EXEC classes, store ack, or WB.
    assign retire = (state == S_EXEC && !is_load && !is_store)
                 || (state == S_MEM && is_store && mem_ready)
                 || (state == S_WB);

    always_comb begin
        InstrLoad = 1'b0;
        PCWrite   = 1'b0;
        Branch    = 1'b0;
        ALUSrc    = 1'b0;
        ALUOp     = ALUW'(ALU_PASS);
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        halted    = (state == S_HALT);
        unique case (state)
            S_FETCH: InstrLoad = 1'b1;
            S_EXEC: begin
                ALUSrc = d_alusrc;
                ALUOp  = d_aluop;
                if (is_alu) begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                end else if (is_branch) begin
                    PCWrite = 1'b1;
                    Branch  = zero;
                end else if (!is_load && !is_store && !is_halt) begin
                    PCWrite = 1'b1;
                end
            end
            S_MEM: begin
                MemRead  = is_load;
                MemWrite = is_store;
                PCWrite  = is_store && mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                PCWrite  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ir_op    <= '0;
            wait_cnt <= '0;
            retired  <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (retire && retired != {CNTW{1'b1}})
                retired <= retired + 1'b1;
            unique case (state)
                S_IDLE:   if (start) state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    ir_op <= instr;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        wait_cnt <= '0;
                        state    <= S_MEM;
                    end else if (is_halt) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    // A ready on the final allowed cycle still completes.
                    if (mem_ready) begin
                        state <= is_load ? S_WB : S_FETCH;
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem_err <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB:   state <= S_FETCH;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle
// expected outputs, a negedge monitor pops and compares them.
module tb_multicycle_control;

    typedef struct packed {
        logic       il;
        logic       pcw;
        logic       br;
        logic       als;
        logic [2:0] aop;
        logic       rw;
        logic       m2r;
        logic       mr;
        logic       mw;
        logic       hlt;
        logic       err;
        logic [1:0] ret;
    } out_t;

    typedef struct {
        string nm;
        out_t  e;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] instr;
    logic       zero;
    logic       mem_ready;
    logic       InstrLoad, PCWrite, Branch, ALUSrc;
    logic [2:0] ALUOp;
    logic       RegWrite, MemtoReg, MemRead, MemWrite;
    logic       halted, mem_err;
    logic [1:0] retired;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [1:0] ret;

    always #5 clk = ~clk;

    multicycle_control #(
        .OPW      (4),
        .ALUW     (3),
        .MAX_WAIT (8),
        .CNTW     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .instr     (instr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .InstrLoad (InstrLoad),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .ALUSrc    (ALUSrc),
        .ALUOp     (ALUOp),
        .RegWrite  (RegWrite),
        .MemtoReg  (MemtoReg),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .halted    (halted),
        .mem_err   (mem_err),
        .retired   (retired)
    );

    always @(negedge clk) begin
        exp_t x;
        out_t g;
        if (q.size() > 0) begin
            x = q.pop_front();
            g.il  = InstrLoad;
            g.pcw = PCWrite;
            g.br  = Branch;
            g.als = ALUSrc;
            g.aop = ALUOp;
            g.rw  = RegWrite;
            g.m2r = MemtoReg;
            g.mr  = MemRead;
            g.mw  = MemWrite;
            g.hlt = halted;
            g.err = mem_err;
            g.ret = retired;
            total++;
            if (g !== x.e) begin
                bad++;
                $display("FAIL %s got=%b exp=%b (il pcw br als aop rw m2r mr mw hlt err ret)",
                         x.nm, g, x.e);
            end
        end
    end

    function automatic out_t idle(input logic [1:0] r);
        out_t e;
        e     = '0;
        e.aop = 3'b111;
        e.ret = r;
        return e;
    endfunction

    function automatic logic [1:0] sat(input logic [1:0] r);
        return (r == 2'd3) ? r : r + 2'd1;
    endfunction

    task automatic step(input string nm, input out_t e);
        exp_t x;
        x.nm = nm;
        x.e  = e;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ret   = 2'd0;
        step("reset", idle(2'd0));
    endtask

    task automatic go(input logic [3:0] op);
        instr = op;
        start = 1'b1;
        step("idle", idle(ret));
        start = 1'b0;
    endtask

    task automatic fd(input string nm);
        out_t e;
        e    = idle(ret);
        e.il = 1'b1;
        step({nm, ":fetch"}, e);
        step({nm, ":decode"}, idle(ret));
    endtask

    task automatic ex(input string nm, input logic als, input logic [2:0] aop,
                      input logic rw, input logic pcw, input logic br,
                      input logic rt);
        out_t e;
        e     = idle(ret);
        e.als = als;
        e.aop = aop;
        e.rw  = rw;
        e.pcw = pcw;
        e.br  = br;
        step({nm, ":exec"}, e);
        if (rt) ret = sat(ret);
    endtask

    task automatic mem(input string nm, input logic ld, input logic rdy);
        out_t e;
        mem_ready = rdy;
        e     = idle(ret);
        e.mr  = ld;
        e.mw  = !ld;
        e.pcw = !ld && rdy;
        step({nm, ":mem"}, e);
        if (rdy && !ld) ret = sat(ret);
        mem_ready = 1'b0;
    endtask

    logic [3:0] ops[9] = '{4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hE};
    logic       als_t[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] aop_t[9] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011,
                             3'b100, 3'b101, 3'b111, 3'b111};
    logic       rw_t[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        out_t e;
        reset = 1'b1;
        start = 1'b0;
        instr = 4'h0;
        zero = 1'b0;
        mem_ready = 1'b0;
        ret = 2'd0;

        // ALU ops and NOPs back to back; counter saturates at 3, then halt.
        do_reset();
        go(ops[0]);
        for (int i = 0; i < 9; i++) begin
            instr = ops[i];
            fd($sformatf("op%0h", ops[i]));
            ex($sformatf("op%0h", ops[i]), als_t[i], aop_t[i], rw_t[i],
               1'b1, 1'b0, 1'b1);
        end
        instr = 4'hF;
        fd("halt");
        ex("halt", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        e = idle(ret);
        e.hlt = 1'b1;
        step("halt:hold1", e);
        step("halt:hold2", e);
        start = 1'b0;

        // Load with two wait cycles.
        do_reset();
        go(4'h2);
        fd("ld");
        ex("ld", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        mem("ld:w0", 1'b1, 1'b0);
        mem("ld:w1", 1'b1, 1'b0);
        mem("ld:rdy", 1'b1, 1'b1);
        e = idle(ret);
        e.rw = 1'b1;
        e.m2r = 1'b1;
        e.pcw = 1'b1;
        step("ld:wb", e);
        ret = sat(ret);
        e = idle(ret);
        e.il = 1'b1;
        step("ld:next", e);

        // Branch taken then not taken.
        do_reset();
        go(4'h3);
        fd("bz1");
        zero = 1'b1;
        ex("bz1", 1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1);
        fd("bz0");
        zero = 1'b0;
        ex("bz0", 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
        e = idle(ret);
        e.il = 1'b1;
        step("bz:next", e);

        // Store never acknowledged: timeout into HALT.
        do_reset();
        go(4'h0);
        fd("sto");
        ex("sto", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) mem($sformatf("sto:w%0d", i), 1'b0, 1'b0);
        start = 1'b1;
        e = idle(ret);
        e.hlt = 1'b1;
        e.err = 1'b1;
        step("sto:halt1", e);
        step("sto:halt2", e);
        start = 1'b0;

        // Store acknowledged on the last allowed cycle completes normally.
        do_reset();
        go(4'h0);
        fd("stl");
        ex("stl", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) mem($sformatf("stl:w%0d", i), 1'b0, 1'b0);
        mem("stl:rdy", 1'b0, 1'b1);
        e = idle(ret);
        e.il = 1'b1;
        step("stl:next", e);

        // Reset in the middle of a store wait.
        do_reset();
        go(4'h1);
        fd("pre");
        ex("pre", 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1);
        instr = 4'h0;
        fd("str");
        ex("str", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        mem("str:w0", 1'b0, 1'b0);
        reset = 1'b1;
        mem("str:w1", 1'b0, 1'b0);
        reset = 1'b0;
        ret = 2'd0;
        step("str:after_reset", idle(2'd0));
        step("str:idle", idle(2'd0));

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
